// File: rtl/alu_exec_stage_pkg.sv
// Shared definitions for the execute stage: width defaults (kept in step with
// the register file), opcode values and FSM state encodings.
package alu_exec_stage_pkg;

  localparam int unsigned DSIZE_DEF = 16;
  localparam int unsigned RSIZE_DEF = 4;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_SLL = 3'b100,
    OP_SRL = 3'b101,
    OP_MUL = 3'b110,
    OP_RSV = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_WB   = 2'd2
  } state_e;

endpackage

// File: rtl/alu_exec_stage_alu_comb.sv
// Purely combinational single-cycle ALU. MUL and reserved opcodes yield 0 here;
// the multi-cycle multiply lives in alu_exec_stage.
module alu_comb
  import alu_exec_stage_pkg::*;
#(
  parameter int unsigned DSIZE = DSIZE_DEF
) (
  input  logic [2:0]       op,
  input  logic [DSIZE-1:0] a,
  input  logic [DSIZE-1:0] b,
  output logic [DSIZE-1:0] result
);

  localparam int unsigned SH = $clog2(DSIZE);

  logic [SH-1:0] shamt;

  assign shamt = b[SH-1:0];

  always_comb begin
    result = '0;
    case (op)
      OP_ADD:  result = a + b;
      OP_SUB:  result = a - b;
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_SLL:  result = a << shamt;
      OP_SRL:  result = a >> shamt;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/alu_exec_stage.sv
// Execute stage: one ALU op per Start, registered write-back to the register file.
// Define ALU_MUL_EN to build the multi-cycle shift-add MUL for opcode 110.
module alu_exec_stage
  import alu_exec_stage_pkg::*;
#(
  parameter int unsigned DSIZE = DSIZE_DEF,
  parameter int unsigned RSIZE = RSIZE_DEF
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Start,
  input  logic [2:0]       Op,
  input  logic [DSIZE-1:0] OpA,
  input  logic [DSIZE-1:0] OpB,
  input  logic [RSIZE-1:0] DstAddr,
  output logic             Busy,
  output logic             Done,
  output logic             Zero,
  output logic             Wen,
  output logic [RSIZE-1:0] WAddr,
  output logic [DSIZE-1:0] WData
);

  state_e state_q, state_d;

  logic [DSIZE-1:0] alu_res;
  logic [DSIZE-1:0] res_q;
  logic [RSIZE-1:0] dst_q;
  logic             done_q;
  logic             zero_q;
  logic [RSIZE-1:0] waddr_q;
  logic [DSIZE-1:0] wdata_q;

`ifdef ALU_MUL_EN
  localparam int unsigned CW = $clog2(DSIZE + 1);

  logic [DSIZE-1:0] mcand_q;
  logic [DSIZE-1:0] mplier_q;
  logic [CW-1:0]    cnt_q;
`endif

  alu_comb #(.DSIZE(DSIZE)) u_alu (
    .op     (Op),
    .a      (OpA),
    .b      (OpB),
    .result (alu_res)
  );

  always_ff @(posedge Clock) begin
    if (!Reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (Start) begin
          state_d = ST_WB;
`ifdef ALU_MUL_EN
          if (Op == OP_MUL) state_d = ST_MUL;
`endif
        end
      end
      ST_MUL: begin
`ifdef ALU_MUL_EN
        // Last iteration: counter is about to reach 0.
        if (cnt_q == CW'(1)) state_d = ST_WB;
`else
        state_d = ST_IDLE;
`endif
      end
      ST_WB:   state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // res_q doubles as the MUL accumulator so WB has a single result source.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      res_q    <= '0;
      dst_q    <= '0;
      done_q   <= 1'b0;
      zero_q   <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
`ifdef ALU_MUL_EN
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (Start) begin
            dst_q <= DstAddr;
            res_q <= alu_res;
`ifdef ALU_MUL_EN
            if (Op == OP_MUL) begin
              mcand_q  <= OpA;
              mplier_q <= OpB;
              res_q    <= '0;
              cnt_q    <= CW'(DSIZE);
            end
`endif
          end
        end
        ST_MUL: begin
`ifdef ALU_MUL_EN
          if (mplier_q[0]) res_q <= res_q + mcand_q;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q - CW'(1);
`endif
        end
        ST_WB: begin
          done_q  <= 1'b1;
          wdata_q <= res_q;
          waddr_q <= dst_q;
          zero_q  <= (res_q == '0);
        end
        default: ;
      endcase
    end
  end

  assign Busy  = (state_q != ST_IDLE);
  assign Done  = done_q;
  assign Wen   = done_q;
  assign Zero  = zero_q;
  assign WAddr = waddr_q;
  assign WData = wdata_q;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed self-checking bench for alu_exec_stage with a small register file
// model attached to the write port. Define ALU_MUL_EN to exercise MUL.
module tb_alu_exec_stage;
  import alu_exec_stage_pkg::*;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        Start;
  logic [2:0]  Op;
  logic [15:0] OpA;
  logic [15:0] OpB;
  logic [3:0]  DstAddr;
  logic        Busy;
  logic        Done;
  logic        Zero;
  logic        Wen;
  logic [3:0]  WAddr;
  logic [15:0] WData;

  int unsigned checks = 0;
  int unsigned failures = 0;
  int unsigned wen_count = 0;

  logic [15:0] rf [16];

  alu_exec_stage #(.DSIZE(16), .RSIZE(4)) dut (
    .Clock   (Clock),
    .Reset   (Reset),
    .Start   (Start),
    .Op      (Op),
    .OpA     (OpA),
    .OpB     (OpB),
    .DstAddr (DstAddr),
    .Busy    (Busy),
    .Done    (Done),
    .Zero    (Zero),
    .Wen     (Wen),
    .WAddr   (WAddr),
    .WData   (WData)
  );

  always #5 Clock = ~Clock;

  always @(posedge Clock) if (Wen) rf[WAddr] <= WData;

  always @(negedge Clock) if (Wen) wen_count++;

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input string tag, input logic [2:0] op, input logic [15:0] a,
                        input logic [15:0] b, input logic [3:0] dst,
                        input logic [15:0] exp, input logic expz);
    Start = 1'b1; Op = op; OpA = a; OpB = b; DstAddr = dst;
    tick();
    Start = 1'b0; Op = OP_RSV; OpA = ~a; OpB = ~b; DstAddr = ~dst;
    check({tag, ".busy_wb"}, 32'(Busy), 32'd1);
    check({tag, ".done_early"}, 32'(Done), 32'd0);
    tick();
    check({tag, ".done"}, 32'(Done), 32'd1);
    check({tag, ".wen"}, 32'(Wen), 32'd1);
    check({tag, ".wdata"}, 32'(WData), 32'(exp));
    check({tag, ".waddr"}, 32'(WAddr), 32'(dst));
    check({tag, ".zero"}, 32'(Zero), 32'(expz));
    check({tag, ".busy_after"}, 32'(Busy), 32'd0);
  endtask

  task automatic issue(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                       input logic [3:0] dst);
    Start = 1'b1; Op = op; OpA = a; OpB = b; DstAddr = dst;
    tick();
    Start = 1'b0;
    tick();
  endtask

`ifdef ALU_MUL_EN
  task automatic run_mul(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic [3:0] dst, input logic [15:0] exp);
    int unsigned cycles;
    int unsigned busy_cnt;
    int unsigned w0;
    w0 = wen_count;
    Start = 1'b1; Op = OP_MUL; OpA = a; OpB = b; DstAddr = dst;
    tick();
    Start = 1'b0; OpA = 16'h1111; OpB = 16'h2222;
    cycles = 0;
    busy_cnt = 0;
    while (!Done && cycles < 40) begin
      if (Busy) busy_cnt++;
      Start = (cycles == 4 || cycles == 5);
      Op = OP_ADD;
      tick();
      cycles++;
    end
    Start = 1'b0;
    check({tag, ".latency"}, cycles, 32'd17);
    check({tag, ".busy_cycles"}, busy_cnt, 32'd17);
    check({tag, ".wdata"}, 32'(WData), 32'(exp));
    check({tag, ".waddr"}, 32'(WAddr), 32'(dst));
    check({tag, ".zero"}, 32'(Zero), 32'(exp == 16'h0000));
    tick();
    tick();
    check({tag, ".done_pulse"}, 32'(Done), 32'd0);
    check({tag, ".one_write"}, wen_count - w0, 32'd1);
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned w0;
    for (int i = 0; i < 16; i++) rf[i] = 16'hDEAD;

    Reset = 1'b0; Start = 1'b1; Op = OP_ADD; OpA = 16'h1234; OpB = 16'h4321; DstAddr = 4'h7;
    tick();
    tick();
    check("rst.busy", 32'(Busy), 32'd0);
    check("rst.done", 32'(Done), 32'd0);
    check("rst.wen", 32'(Wen), 32'd0);
    check("rst.zero", 32'(Zero), 32'd0);
    check("rst.waddr", 32'(WAddr), 32'd0);
    check("rst.wdata", 32'(WData), 32'd0);

    Start = 1'b0; Reset = 1'b1;
    tick();
    tick();
    check("idle.busy", 32'(Busy), 32'd0);
    check("idle.done", 32'(Done), 32'd0);

    run_op("add", OP_ADD, 16'hFFFF, 16'h0001, 4'h3, 16'h0000, 1'b1);
    tick();
    check("zero_held", 32'(Zero), 32'd1);
    check("wdata_held", 32'(WData), 32'h0000);
    run_op("sub", OP_SUB, 16'h0005, 16'h0007, 4'h5, 16'hFFFE, 1'b0);
    run_op("and", OP_AND, 16'hF0F0, 16'h3C3C, 4'h0, 16'h3030, 1'b0);
    run_op("or",  OP_OR,  16'hF0F0, 16'h3C3C, 4'hF, 16'hFCFC, 1'b0);
    run_op("sll", OP_SLL, 16'h0001, 16'h0013, 4'h9, 16'h0008, 1'b0);
    run_op("srl", OP_SRL, 16'h8000, 16'h000F, 4'hA, 16'h0001, 1'b0);
    run_op("rsv", OP_RSV, 16'h0003, 16'h0004, 4'h2, 16'h0000, 1'b1);

`ifdef ALU_MUL_EN
    run_mul("mul1", 16'h0123, 16'h0010, 4'h4, 16'h1230);
    run_mul("mul2", 16'hFFFF, 16'hFFFF, 4'hB, 16'h0001);

    Start = 1'b1; Op = OP_MUL; OpA = 16'h00FF; OpB = 16'h00FF; DstAddr = 4'h6;
    tick();
    Start = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    Reset = 1'b0;
    tick();
`else
    run_op("mul_off", OP_MUL, 16'h0003, 16'h0004, 4'h8, 16'h0000, 1'b1);

    Start = 1'b1; Op = OP_ADD; OpA = 16'h0010; OpB = 16'h0020; DstAddr = 4'h6;
    tick();
    Start = 1'b0;
    Reset = 1'b0;
    tick();
`endif
    check("abort.busy", 32'(Busy), 32'd0);
    check("abort.done", 32'(Done), 32'd0);
    check("abort.wdata", 32'(WData), 32'd0);
    Reset = 1'b1;
    w0 = wen_count;
    for (int i = 0; i < 20; i++) tick();
    check("abort.no_write", wen_count - w0, 32'd0);
    run_op("add_after", OP_ADD, 16'h0002, 16'h0003, 4'h1, 16'h0005, 1'b0);

    for (int i = 0; i < 16; i++) issue(OP_ADD, 16'(i), 16'd16, 4'(i));
    tick();
    for (int i = 0; i < 16; i++) check($sformatf("rf[%0d]", i), 32'(rf[i]), 32'(i + 16));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_exec_stage.md
Name: alu_exec_stage

Overview:
- Execute stage directly downstream of the register file.
- Consumes the two register read operands, performs one ALU operation per request, and produces a write-back (Wen/WAddr/WData) for the register file write port.
- Single-cycle ops take one cycle; MUL is a multi-cycle shift-add.
- A Start/Busy/Done handshake lets the controller sequence requests.

Parameters:
- DSIZE, 16: data width; must match register file data width.
- RSIZE, 4: register address width; must match register file address width.

Ports:
- Clock  in  1  system clock; all state updates on the rising edge.
- Reset  in  1  synchronous, active-low reset; sampled on the rising edge of Clock.
- Start  in  1  request strobe; sampled only in IDLE.
- Op  in  3  operation code; latched with Start.
- OpA  in  DSIZE  operand A (register file RData1).
- OpB  in  DSIZE  operand B (register file RData2).
- DstAddr  in  RSIZE  destination register; latched with Start.
- Busy  out  1  high whenever state is not IDLE.
- Done  out  1  one-cycle pulse when the result is valid.
- Zero  out  1  result == 0; valid while Done is high, held afterwards.
- Wen  out  1  register file write enable; equals Done.
- WAddr  out  RSIZE  register file write address.
- WData  out  DSIZE  register file write data (the result).

Behaviour:
- Reset (Reset==0 at an edge):
  - state goes to IDLE.
  - Busy, Done, Wen, Zero, WAddr and WData all go to 0.
  - Any in-progress op is aborted with no write-back.
  - Reset has priority over every other input.
- Opcodes:
  - 000 ADD: A+B, mod 2^DSIZE.
  - 001 SUB: A-B, mod 2^DSIZE.
  - 010 AND: A&B.
  - 011 OR: A|B.
  - 100 SLL: A << B[log2(DSIZE)-1:0].
  - 101 SRL: A >> B[log2(DSIZE)-1:0], logical.
  - 110 MUL: low DSIZE bits of A*B, unsigned.
  - 111 reserved: result 0.
  - No carry or overflow outputs.
- State machine, IDLE -> MUL -> WB:
  - In IDLE with Start==1, latch Op, OpA, OpB and DstAddr.
  - Op != 110: compute the result in the same edge and go to WB.
  - Op == 110: load the multiplicand, multiplier and accumulator (cleared), load the counter with DSIZE, and go to MUL.
  - In MUL, each cycle: if multiplier[0], acc += multiplicand; multiplicand <<= 1; multiplier >>= 1; counter--. When the counter reaches 0, go to WB. MUL therefore occupies exactly DSIZE cycles.
  - In WB: Done=Wen=1, WData=result, WAddr=latched DstAddr, Zero=(result==0). Next state is IDLE.
- Latency (all outputs registered):
  - Start sampled at edge N, non-MUL: Done/Wen high during the cycle after edge N+1.
  - MUL: Done/Wen high during the cycle after edge N+1+DSIZE.
- Handshake:
  - Start is ignored while Busy (MUL and WB).
  - Back-to-back issue is allowed: Start may be asserted in the cycle following WB.
  - Maximum throughput is one non-MUL op every 2 cycles.
- Zero: updated only in WB; held until the next WB or reset.
- DstAddr 0 is written like any other address; the register file decides what to do with it.
- Operand inputs may change freely after Start is sampled, because all operands are latched.

Optional Feature:
- Macro: ALU_MUL_EN.
- Defined: opcode 110 is the multi-cycle MUL described above, and the MUL state exists.
- Undefined:
  - The MUL state and its datapath are not built.
  - Opcode 110 behaves like 111: single-cycle, result 0, normal WB with Wen=1.

Decomposition:
- Shared package/header holds:
  - DSIZE and RSIZE defaults, shared with the register file.
  - Opcode constants OP_ADD .. OP_RSV.
  - State encodings ST_IDLE, ST_MUL, ST_WB.
- One natural sub-module, alu_comb: a purely combinational single-cycle ALU (Op, A, B -> result).
  - alu_exec_stage instantiates it and owns the FSM, the MUL datapath and the write-back registers.

Test Plan:
- Reset: hold Reset=0 for 2 cycles with Start=1 -> Busy=Done=Wen=Zero=0 and WAddr=WData=0. Release Reset -> still idle until a Start is sampled.
- ALU sweep (DSIZE=16):
  - ADD 0xFFFF+0x0001 -> WData=0x0000, Zero=1.
  - SUB 0x0005-0x0007 -> 0xFFFE.
  - AND 0xF0F0&0x3C3C -> 0x3030.
  - OR -> 0xFCFC.
  - SLL 0x0001 by B=0x0013 -> 0x0008 (low 4 bits used).
  - SRL 0x8000 by 15 -> 0x0001.
  - Each case: Done/Wen pulse exactly one cycle after the Start edge, with WAddr=DstAddr.
- MUL (ALU_MUL_EN defined):
  - 0x0123*0x0010 -> 0x1230.
  - 0xFFFF*0xFFFF -> 0x0001.
  - Busy high for 17 cycles, Done after exactly 16 MUL cycles.
  - Start pulses issued mid-MUL are ignored and produce no extra writes.
- MUL with ALU_MUL_EN undefined: Op=110, A=3, B=4 -> single-cycle WB with WData=0 and Zero=1.
- Reset mid-MUL: assert Reset at MUL cycle 8 -> no Wen pulse, Busy=0 next cycle. A new ADD 2+3 afterwards -> WData=5.
- Register file integration: for i=0..15, issue ADD with A=i, B=16, DstAddr=i, wired into the register file. Then read all 16 addresses -> RData=i+16 for each.
